// File: rtl/aes_decrypt_iterative.sv
// rtl/aes_decrypt_iterative.sv - iterative AES inverse cipher, one inverse round per clock
//
// Ports:
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready     ciphertext + key schedule handshake (ready only in IDLE)
//   ciphertext              128-bit block, byte 0 at [127:120]
//   key_schedule            round key i at [128*i +: 128], i=0 is the cipher key
//   out_valid / out_ready   plaintext handshake (valid only in DONE)
//   plaintext               decrypted block, zero outside DONE
//   round_index             inverse round counter while in ROUND, else 0
module aes_decrypt_iterative #(
    parameter int NR = 10
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [127:0]            ciphertext,
    input  logic [128*(NR+1)-1:0]   key_schedule,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [127:0]            plaintext,
    output logic [3:0]              round_index
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

    fsm_t                   st, st_n;
    logic [127:0]           blk, blk_n;
    logic [128*(NR+1)-1:0]  ks, ks_n;
    logic [3:0]             rcnt, rcnt_n;
    logic [127:0]           rk [0:NR];
    logic [127:0]           inv_core;

    // GF(2^8) multiply, reduction polynomial 0x11B
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (0 maps to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine transform, then invert in GF(2^8)
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] y;
        y = '0;
        for (int i = 0; i < 8; i++)
            y[i] = a[(i+2)%8] ^ a[(i+5)%8] ^ a[(i+7)%8];
        return gf_inv(y ^ 8'h05);
    endfunction

    // Byte n sits at [127-8n -: 8]; row = n%4, column = n/4
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++)
            o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi <= NR; gi++) begin : g_rk
            assign rk[gi] = ks[128*gi +: 128];
        end
    endgenerate

    // Shared by ROUND and FINAL; FINAL simply skips InvMixColumns
    assign inv_core = inv_sub_bytes(inv_shift_rows(blk));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st   <= IDLE;
            blk  <= '0;
            ks   <= '0;
            rcnt <= '0;
        end else begin
            st   <= st_n;
            blk  <= blk_n;
            ks   <= ks_n;
            rcnt <= rcnt_n;
        end
    end

    always_comb begin
        st_n   = st;
        blk_n  = blk;
        ks_n   = ks;
        rcnt_n = rcnt;
        case (st)
            IDLE: begin
                if (in_valid) begin
                    ks_n   = key_schedule;
                    blk_n  = ciphertext ^ key_schedule[128*NR +: 128];
                    rcnt_n = 4'(NR - 1);
                    st_n   = ROUND;
                end
            end
            ROUND: begin
                blk_n  = inv_mix_columns(inv_core ^ rk[rcnt]);
                rcnt_n = rcnt - 4'd1;
                if (rcnt == 4'd1) st_n = FINAL;
            end
            FINAL: begin
                blk_n  = inv_core ^ rk[0];
                rcnt_n = '0;
                st_n   = DONE;
            end
            DONE: begin
                if (out_ready) st_n = IDLE;
            end
            default: st_n = IDLE;
        endcase
    end

    assign in_ready    = (st == IDLE);
    assign out_valid   = (st == DONE);
    assign plaintext   = (st == DONE) ? blk : '0;
    assign round_index = (st == ROUND) ? rcnt : 4'd0;

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// tb/tb_aes_decrypt_iterative.sv - directed self-checking bench for aes_decrypt_iterative
module tb_aes_decrypt_iterative;

    logic           clock = 1'b0;
    logic           reset_n;
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   ciphertext;
    logic [1407:0]  key_schedule;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   plaintext;
    logic [3:0]     round_index;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [127:0] v_key [0:3];
    logic [127:0] v_ct  [0:3];
    logic [127:0] v_pt  [0:3];

    aes_decrypt_iterative #(.NR(10)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ciphertext   (ciphertext),
        .key_schedule (key_schedule),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .plaintext    (plaintext),
        .round_index  (round_index)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Bench-side GF arithmetic and forward S-box for key expansion
    function automatic logic [7:0] b_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] aa;
        logic [7:0] bb;
        r = 8'h00; aa = a; bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) r = r ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] b_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 1; k < 256; k++)
            if (b_mul(a, 8'(k)) == 8'h01) r = 8'(k);
        return r;
    endfunction

    function automatic logic [7:0] b_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = b_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   w [0:43];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] ks;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {b_sbox(t[31:24]), b_sbox(t[23:16]), b_sbox(t[15:8]), b_sbox(t[7:0])} ^ {rc, 24'h0};
                rc = b_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [127:0] ct, input logic [1407:0] ks);
        ciphertext   = ct;
        key_schedule = ks;
        in_valid     = 1'b1;
        tick();
        in_valid     = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ciphertext = '0; key_schedule = '0;
        tick(); tick();
        reset_n = 1'b1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests_run++; if (plaintext !== 128'h0) begin tests_failed++; $display("FAIL reset_plaintext got %h exp 0", plaintext); end
        tests_run++; if (round_index !== 4'd0) begin tests_failed++; $display("FAIL reset_round_index got %0d exp 0", round_index); end
        tick();
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_first_edge_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_fips_b;
        int n;
        send(v_ct[0], expand(v_key[0]));
        tests_run++; if (round_index !== 4'd9) begin tests_failed++; $display("FAIL b_first_round_index got %0d exp 9", round_index); end
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL b_busy_in_ready got %b exp 0", in_ready); end
        wait_out(n);
        tests_run++; if (n !== 10) begin tests_failed++; $display("FAIL b_latency got %0d exp 10", n); end
        tests_run++; if (plaintext !== v_pt[0]) begin tests_failed++; $display("FAIL b_plaintext got %h exp %h", plaintext, v_pt[0]); end
        tests_run++; if (round_index !== 4'd0) begin tests_failed++; $display("FAIL b_done_round_index got %0d exp 0", round_index); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        tests_run++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL b_release got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid); end
    endtask

    task automatic test_fips_c1;
        int n;
        send(v_ct[1], expand(v_key[1]));
        wait_out(n);
        tests_run++; if (n !== 10) begin tests_failed++; $display("FAIL c1_latency got %0d exp 10", n); end
        tests_run++; if (plaintext !== v_pt[1]) begin tests_failed++; $display("FAIL c1_plaintext got %h exp %h", plaintext, v_pt[1]); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL c1_release_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_backpressure;
        int n;
        int bad_pt;
        int bad_rdy;
        send(v_ct[0], expand(v_key[0]));
        wait_out(n);
        tests_run++; if (n !== 10) begin tests_failed++; $display("FAIL bp_latency got %0d exp 10", n); end
        bad_pt = 0; bad_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b0;
            tick();
            if (plaintext !== v_pt[0] || out_valid !== 1'b1) bad_pt++;
            if (in_ready !== 1'b0) bad_rdy++;
        end
        tests_run++; if (bad_pt !== 0) begin tests_failed++; $display("FAIL bp_hold_plaintext got %0d unstable cycles exp 0", bad_pt); end
        tests_run++; if (bad_rdy !== 0) begin tests_failed++; $display("FAIL bp_hold_in_ready got %0d ready cycles exp 0", bad_rdy); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        tests_run++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid); end
    endtask

    task automatic test_isolation;
        int n;
        int rdy_seen;
        send(v_ct[0], expand(v_key[0]));
        n = 0; rdy_seen = 0;
        while (!out_valid && n < 40) begin
            in_valid   = n[0];
            ciphertext = {$urandom, $urandom, $urandom, $urandom};
            for (int w = 0; w < 44; w++) key_schedule[32*w +: 32] = $urandom;
            if (in_ready) rdy_seen++;
            tick();
            n++;
        end
        in_valid = 1'b0;
        tests_run++; if (n !== 10) begin tests_failed++; $display("FAIL iso_latency got %0d exp 10", n); end
        tests_run++; if (rdy_seen !== 0) begin tests_failed++; $display("FAIL iso_in_ready got %0d ready cycles exp 0", rdy_seen); end
        tests_run++; if (plaintext !== v_pt[0]) begin tests_failed++; $display("FAIL iso_plaintext got %h exp %h", plaintext, v_pt[0]); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int n;
        send(v_ct[0], expand(v_key[0]));
        n = 0;
        while (round_index !== 4'd5 && n < 20) begin
            tick();
            n++;
        end
        tests_run++; if (round_index !== 4'd5) begin tests_failed++; $display("FAIL mid_reach_round5 got %0d exp 5", round_index); end
        reset_n = 1'b0;
        #1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_out_valid got %b exp 0", out_valid); end
        tests_run++; if (plaintext !== 128'h0) begin tests_failed++; $display("FAIL mid_plaintext got %h exp 0", plaintext); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_in_ready got %b exp 1", in_ready); end
        tests_run++; if (round_index !== 4'd0) begin tests_failed++; $display("FAIL mid_round_index got %0d exp 0", round_index); end
        tick();
        reset_n = 1'b1;
        tick();
        test_fips_c1();
    endtask

    task automatic test_back_to_back;
        logic [1407:0] ks_arr [0:3];
        int acc [0:3];
        int j;
        int gm;
        for (int i = 0; i < 4; i++) ks_arr[i] = expand(v_key[i]);
        out_ready = 1'b1;
        j = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    int g;
                    ciphertext   = v_ct[i];
                    key_schedule = ks_arr[i];
                    in_valid     = 1'b1;
                    g = 0;
                    while (!in_ready && g < 40) begin
                        tick();
                        g++;
                    end
                    acc[i] = cyc;
                    tick();
                end
                in_valid = 1'b0;
            end
            begin
                gm = 0;
                while (j < 4 && gm < 200) begin
                    tick();
                    gm++;
                    if (out_valid) begin
                        tests_run++;
                        if (plaintext !== v_pt[j]) begin tests_failed++; $display("FAIL b2b_plaintext_%0d got %h exp %h", j, plaintext, v_pt[j]); end
                        j++;
                    end
                end
            end
        join
        out_ready = 1'b0;
        tests_run++; if (j !== 4) begin tests_failed++; $display("FAIL b2b_block_count got %0d exp 4", j); end
        for (int i = 1; i < 4; i++) begin
            tests_run++;
            if (acc[i] - acc[i-1] !== 12) begin tests_failed++; $display("FAIL b2b_accept_spacing_%0d got %0d exp 12", i, acc[i] - acc[i-1]); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        v_key[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        v_ct[0]  = 128'h3925841d02dc09fbdc118597196a0b32;
        v_pt[0]  = 128'h3243f6a8885a308d313198a2e0370734;
        v_key[1] = 128'h000102030405060708090a0b0c0d0e0f;
        v_ct[1]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        v_pt[1]  = 128'h00112233445566778899aabbccddeeff;
        v_key[2] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        v_ct[2]  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        v_pt[2]  = 128'h6bc1bee22e409f96e93d7e117393172a;
        v_key[3] = 128'h00000000000000000000000000000000;
        v_ct[3]  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
        v_pt[3]  = 128'h00000000000000000000000000000000;

        test_reset();
        test_fips_b();
        test_fips_c1();
        test_backpressure();
        test_isolation();
        test_reset_mid();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
